// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- clocked ALU with operand latches, start/busy/done handshake,
//            an iterative shift-add multiplier and registered result/flags.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   ai, bi  in   1      load operand register A / B from a / b (when not busy)
//   a, b    in   WIDTH  operand data
//   sel     in   SEL_W  opcode, sampled together with an accepted start
//   start   in   1      launch an operation; ignored while busy
//   oe      in   1      output enable for out
//   out     out  WIDTH  result register gated by oe
//   flags   out  7      registered {LT,EQ,P,V,C,N,Z}, bit6..bit0
//   busy    out  1      high while a multiply is in flight
//   done    out  1      one-cycle pulse in the cycle result/flags change
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ai,
    input  logic             bi,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    input  logic             start,
    input  logic             oe,
    output logic [WIDTH-1:0] out,
    output logic [6:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // EXEC is the cycle in which done is high, for both single-cycle ops
    // and the final cycle of a multiply.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_NAND = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_reg_q, a_reg_d;
    logic [WIDTH-1:0]     b_reg_q, b_reg_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;     // multiplicand captured at start
    logic [WIDTH-1:0]     op_b_q, op_b_d;     // multiplier copy kept for EQ/LT
    logic [2*WIDTH-1:0]   prod_q, prod_d;     // {partial sum, remaining multiplier}
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [6:0]           flags_q, flags_d;

    logic [WIDTH-1:0]     eff_a, eff_b;
    op_e                  op_w;
    logic                 is_mul;
    logic                 in_mul;
    logic                 mul_last;
    logic [WIDTH:0]       add_w, sub_w;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_v;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_step;
    logic                 mul_ovf;

    function automatic logic [6:0] pack_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v,
                                              input logic eq, input logic lt);
        return {lt, eq, ~^r, v, c, r[WIDTH-1], (r == '0)};
    endfunction

    // Write-through: an operand strobe in the start cycle feeds the bus value
    // straight into the operation while the register loads in parallel.
    assign eff_a    = ai ? a : a_reg_q;
    assign eff_b    = bi ? b : b_reg_q;
    assign op_w     = op_e'(sel);
    assign is_mul   = (op_w == OP_MUL);
    assign in_mul   = (state_q == S_MUL);
    assign mul_last = (cnt_q == CNT_LAST);

    assign add_w = {1'b0, eff_a} + {1'b0, eff_b};
    assign sub_w = {1'b0, eff_a} - {1'b0, eff_b};

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole product right.
    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, op_a_q} : '0);
    assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    assign mul_ovf   = |prod_step[2*WIDTH-1:WIDTH];

    // Single-cycle result path.
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op_w)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (eff_a[WIDTH-1] == eff_b[WIDTH-1]) &&
                          (add_w[WIDTH-1] != eff_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = ~sub_w[WIDTH];
                alu_v   = (eff_a[WIDTH-1] != eff_b[WIDTH-1]) &&
                          (sub_w[WIDTH-1] != eff_a[WIDTH-1]);
            end
            OP_NAND: alu_res = ~(eff_a & eff_b);
            OP_AND:  alu_res = eff_a & eff_b;
            OP_OR:   alu_res = eff_a | eff_b;
            OP_XOR:  alu_res = eff_a ^ eff_b;
            OP_PASS: alu_res = eff_b;
            default: alu_res = '0;   // MUL takes the iterative path
        endcase
    end

    // FSM: state register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next-state logic. A start is accepted in any non-busy state,
    // including the done cycle, which gives back-to-back issue.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_EXEC: begin
                if (start) state_d = is_mul ? S_MUL : S_EXEC;
                else       state_d = S_IDLE;
            end
            S_MUL:   state_d = mul_last ? S_EXEC : S_MUL;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs (decoded from the registered state, so glitch-free).
    always_comb begin
        busy = (state_q == S_MUL);
        done = (state_q == S_EXEC);
    end

    assign out   = result_q & {WIDTH{oe}};
    assign flags = flags_q;

    // Datapath next-state.
    always_comb begin
        a_reg_d  = a_reg_q;
        b_reg_d  = b_reg_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;

        if (!in_mul) begin
            if (ai) a_reg_d = a;
            if (bi) b_reg_d = b;
            if (start) begin
                if (is_mul) begin
                    op_a_d = eff_a;
                    op_b_d = eff_b;
                    prod_d = {{WIDTH{1'b0}}, eff_b};
                    cnt_d  = '0;
                end else begin
                    result_d = alu_res;
                    flags_d  = pack_flags(alu_res, alu_c, alu_v, eff_a == eff_b,
                                          $signed(eff_a) < $signed(eff_b));
                end
            end
        end else begin
            prod_d = prod_step;
            cnt_d  = cnt_q + CNT_W'(1);
            if (mul_last) begin
                result_d = prod_step[WIDTH-1:0];
                flags_d  = pack_flags(prod_step[WIDTH-1:0], mul_ovf, mul_ovf,
                                      op_a_q == op_b_q,
                                      $signed(op_a_q) < $signed(op_b_q));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg_q  <= '0;
            b_reg_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            a_reg_q  <= a_reg_d;
            b_reg_q  <= b_reg_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=16): reset state, a
// vector table of hand-derived results, handshake corner sequences, and a
// randomized run compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ai, bi, start, oe;
    logic [W-1:0] a, b, out;
    logic [2:0]   sel;
    logic [6:0]   flags;
    logic         busy, done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .SEL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ai    (ai),
        .bi    (bi),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .start (start),
        .oe    (oe),
        .out   (out),
        .flags (flags),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [2:0]   s;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic [6:0]   f;
        int           lat;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for done; lat counts cycles from the start edge.
    task automatic run_op(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic la, input logic lb, output int lat);
        sel = s; a = x; b = y; ai = la; bi = lb; start = 1'b1;
        tick();
        start = 1'b0; ai = 1'b0; bi = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition.
    function automatic void ref_model(input logic [2:0] s, input logic [W-1:0] x,
                                      input logic [W-1:0] y,
                                      output logic [W-1:0] r, output logic [6:0] f);
        int     ux, uy, sx, sy, t;
        longint p;
        logic   c, v;
        ux = int'(x); uy = int'(y);
        sx = (ux >= 32768) ? ux - 65536 : ux;
        sy = (uy >= 32768) ? uy - 65536 : uy;
        c = 1'b0; v = 1'b0;
        case (s)
            3'd0: begin t = ux + uy; r = t[W-1:0]; c = (t > 65535);
                        v = ((sx + sy) > 32767) || ((sx + sy) < -32768); end
            3'd1: begin t = ux - uy; r = t[W-1:0]; c = (ux >= uy);
                        v = ((sx - sy) > 32767) || ((sx - sy) < -32768); end
            3'd2: begin p = longint'(ux) * longint'(uy); r = p[W-1:0];
                        c = (p > 65535); v = c; end
            3'd3: r = ~(x & y);
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = x ^ y;
            default: r = y;
        endcase
        f = {sx < sy, x == y, ($countones(r) % 2) == 0, v, c, r[W-1], r == 0};
    endfunction

    initial begin
        int           lat, c, nb, nd;
        logic [W-1:0] ma, mb, ea, eb, er;
        logic [6:0]   ef;
        logic [2:0]   s;
        logic [W-1:0] x, y;
        logic         la, lb;

        //            sel    a         b         result    flags    latency
        tbl[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 7'h55, 1};
        tbl[1]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 7'h4C, 1};
        tbl[2]  = '{3'd3, 16'hF0F0, 16'hFF00, 16'h0FFF, 7'h50, 1};
        tbl[3]  = '{3'd4, 16'h1234, 16'h00FF, 16'h0034, 7'h00, 1};
        tbl[4]  = '{3'd5, 16'h1200, 16'h0034, 16'h1234, 7'h00, 1};
        tbl[5]  = '{3'd6, 16'hAAAA, 16'hAAAA, 16'h0000, 7'h31, 1};
        tbl[6]  = '{3'd7, 16'h0001, 16'h8000, 16'h8000, 7'h02, 1};
        tbl[7]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 7'h0A, 1};
        tbl[8]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 7'h42, 1};
        tbl[9]  = '{3'd2, 16'h0100, 16'h0103, 16'h0300, 7'h5C, 17};
        tbl[10] = '{3'd2, 16'h00FF, 16'h0101, 16'hFFFF, 7'h52, 17};

        rst_n = 1'b0; ai = 0; bi = 0; a = '0; b = '0; sel = '0; start = 0; oe = 1'b1;
        #12;
        check("reset_out",   32'(out),   32'h0);
        check("reset_flags", 32'(flags), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_done",  32'(done),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].s, tbl[i].x, tbl[i].y, 1'b1, 1'b1, lat);
            check($sformatf("vec%0d_lat", i),   32'(lat),   32'(tbl[i].lat));
            check($sformatf("vec%0d_out", i),   32'(out),   32'(tbl[i].r));
            check($sformatf("vec%0d_flags", i), 32'(flags), 32'(tbl[i].f));
            check($sformatf("vec%0d_busy", i),  32'(busy),  32'h0);
            tick();
            check($sformatf("vec%0d_pulse", i), 32'(done),  32'h0);
            check($sformatf("vec%0d_hold", i),  32'(flags), 32'(tbl[i].f));
        end

        // Output-enable gating on a NAND result.
        run_op(3'd3, 16'hF0F0, 16'hFF00, 1'b1, 1'b1, lat);
        oe = 1'b0; #1;
        check("oe0_out", 32'(out), 32'h0);
        oe = 1'b1; #1;
        check("oe1_out", 32'(out), 32'h0FFF);
        tick();

        // MUL with an ignored start at cycle 8 and a new start in the done cycle.
        sel = 3'd2; a = 16'h0100; b = 16'h0103; ai = 1; bi = 1; start = 1;
        tick();
        start = 0; ai = 0; bi = 0;
        c = 1; nb = 0;
        while (!done && c < 40) begin
            if (busy) nb++;
            start = (c == 8);
            ai    = (c == 8);
            if (c == 8) begin sel = 3'd0; a = 16'hAAAA; end
            tick();
            c++;
        end
        start = 0; ai = 0;
        check("mul_done_cycle", 32'(c),     32'd17);
        check("mul_busy_count", 32'(nb),    32'd16);
        check("mul_busy_low",   32'(busy),  32'h0);
        check("mul_out",        32'(out),   32'h0300);
        check("mul_flags",      32'(flags), 32'h5C);
        sel = 3'd7; b = 16'h1234; bi = 1; start = 1;
        tick();
        start = 0; bi = 0;
        check("donecyc_start_done",  32'(done),  32'h1);
        check("donecyc_start_out",   32'(out),   32'h1234);
        check("donecyc_start_flags", 32'(flags), 32'h40);
        tick();
        run_op(3'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, lat);
        check("busy_ai_ignored", 32'(out), 32'h0100);
        tick();

        // Write-through.
        a = 16'h0001; ai = 1; tick(); ai = 0;
        b = 16'h0003; bi = 1; tick(); bi = 0;
        run_op(3'd0, 16'h0005, 16'hFFFF, 1'b1, 1'b0, lat);
        check("wt_out", 32'(out), 32'h0008);
        run_op(3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat);
        check("wt_reg_loaded", 32'(out), 32'h0008);
        tick();

        // Reset in the middle of a multiply.
        sel = 3'd2; a = 16'h1234; b = 16'h5678; ai = 1; bi = 1; start = 1;
        tick();
        start = 0; ai = 0; bi = 0;
        repeat (4) tick();
        check("midrst_busy_before", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out",   32'(out),   32'h0);
        check("midrst_flags", 32'(flags), 32'h0);
        check("midrst_busy",  32'(busy),  32'h0);
        check("midrst_done",  32'(done),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (25) begin
            tick();
            if (done) nd++;
        end
        check("midrst_no_done", 32'(nd), 32'h0);
        run_op(3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat);
        check("midrst_regs_out",   32'(out),   32'h0);
        check("midrst_regs_flags", 32'(flags), 32'h31);

        // Randomized run; each start lands in the previous done cycle.
        ma = '0; mb = '0;
        for (int i = 0; i < 150; i++) begin
            s  = 3'($urandom_range(0, 7));
            x  = 16'($urandom);
            y  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) y = x;
            if ($urandom_range(0, 7) == 0) x = 16'hFFFF;
            la = (i == 0) || ($urandom_range(0, 1) == 1);
            lb = (i == 0) || ($urandom_range(0, 1) == 1);
            oe = ($urandom_range(0, 3) != 0);
            ea = la ? x : ma;
            eb = lb ? y : mb;
            ref_model(s, ea, eb, er, ef);
            run_op(s, x, y, la, lb, lat);
            if (la) ma = x;
            if (lb) mb = y;
            check($sformatf("rnd%0d_lat", i),   32'(lat),   (s == 3'd2) ? 32'd17 : 32'd1);
            check($sformatf("rnd%0d_out", i),   32'(out),   32'(er & {W{oe}}));
            check($sformatf("rnd%0d_flags", i), 32'(flags), 32'(ef));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
